mesh_term_ni: RTL and testbench
===============================

Name: mesh_term_ni

Overview:
- Terminal network interface for one edge port of the mesh_gnrtr router mesh.
- It is the endpoint the mesh talks to, in place of a testbench driver/monitor pair.
- TX side: buffers host packets and presents them to the router ingress (pndng_i_in/data_out_i_in), advancing on the router's popin.
- RX side: drains router egress (pndng/data_out) by pulsing pop, checks the destination address and hands accepted packets to the host.

Parameters:
- PCKG_SZ, 40, packet width in bits.
- FIFO_DEPTH, 4, depth of the TX and RX buffers (power of two, >=2).
- ID_ROW, 0, row id of this terminal (4 bits used).
- ID_COL, 0, column id of this terminal (4 bits used).
- BDCST, {PCKG_SZ-18{1'b1}}, broadcast address value.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- tx_push  in  1  host write strobe.
- tx_row  in  4  destination row.
- tx_col  in  4  destination column.
- tx_mode  in  1  routing mode (0 column-first, 1 row-first).
- tx_payload  in  PCKG_SZ-17  payload.
- tx_full  out  1  TX buffer full.
- pndng_i_in  out  1  packet pending toward router.
- data_out_i_in  out  PCKG_SZ  head packet toward router.
- popin  in  1  router consumed head packet.
- pndng  in  1  router egress has a packet.
- data_out  in  PCKG_SZ  router egress head packet.
- pop  out  1  consume router egress packet.
- rx_pop  in  1  host read strobe.
- rx_valid  out  1  RX buffer non-empty.
- rx_data  out  PCKG_SZ  RX head packet.
- err_misroute  out  1  one-cycle pulse when a packet is dropped.
- tx_cnt, rx_cnt, drop_cnt  out  CNT_W each  statistics.

Behaviour:
- Packet layout:
  - [PCKG_SZ-1:PCKG_SZ-8] nxt_jmp
  - [PCKG_SZ-9:PCKG_SZ-12] row
  - [PCKG_SZ-13:PCKG_SZ-16] col
  - [PCKG_SZ-17] mode
  - [PCKG_SZ-18:0] payload
- Reset (reset=0, asynchronous): both buffers empty.
  - pop, pndng_i_in, rx_valid, err_misroute, tx_full and all counters are 0.
  - data_out_i_in and rx_data are 0.
  - RX FSM goes to IDLE.
- TX buffer (FIFO):
  - tx_push with tx_full=0 writes {8'h00, tx_row, tx_col, tx_mode, tx_payload}. A push while full is ignored.
  - pndng_i_in = !empty. data_out_i_in = head, combinational from storage.
  - popin removes the head at the clock edge. popin while empty is ignored.
  - Push and pop in the same cycle are both honoured when neither boundary blocks them; occupancy is unchanged.
  - A written packet is visible on pndng_i_in the cycle after the push (1-cycle latency).
- RX FSM:
  - IDLE: if pndng=1 and RX buffer not full, go to POP.
  - POP: pop=1 for exactly one cycle. data_out is sampled in this cycle. Go to GAP.
  - GAP: pop=0 for one cycle so router pndng/data_out can update. Return to IDLE.
  - Maximum drain rate: one packet per 3 cycles. pop is never asserted in consecutive cycles.
- Address check, applied to the sample taken in POP:
  - Accept if row==ID_ROW and col==ID_COL.
  - Also accept if sample[PCKG_SZ-18:0]==BDCST (broadcast; address fields ignored).
  - Accept: write to RX buffer at the POP edge and increment rx_cnt.
  - Reject: drop the packet, pulse err_misroute in the GAP cycle, increment drop_cnt.
- RX buffer full: the FSM stalls in IDLE and pop stays 0; the router holds its packet.
  - rx_pop in the same cycle as a full buffer does not itself enable pop; pop asserts next cycle at the earliest.
- rx_valid = !empty. rx_data = head. rx_pop removes the head; rx_pop while empty is ignored.
- tx_cnt increments on each accepted popin.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-operation aborts any POP/GAP and discards buffered packets. No partial write occurs.

Optional Feature:
- Macro NI_STATS_EN.
- Defined: tx_cnt, rx_cnt and drop_cnt count as described.
- Undefined: counter registers are not built and the three ports are tied to 0. err_misroute remains functional.

Decomposition:
- Package mesh_ni_pkg holds:
  - field offset/width localparams (NXT_JMP_MSB, ROW_MSB, COL_MSB, MODE_BIT, PAYLOAD_W as functions of PCKG_SZ)
  - rx_state_t enum {IDLE, POP, GAP}
  - function make_pkt(row, col, mode, payload)
- Sub-module ni_fifo (parameters width and depth; push/pop/full/empty/head): instantiated twice, once for TX and once for RX.

Test Plan:
- Reset then push row=2,col=1,mode=0,payload=0x5A -> pndng_i_in=1 next cycle; data_out_i_in=0x00_21_0_..5A; popin for one cycle -> pndng_i_in=0; tx_cnt=1.
- Push 5 packets with FIFO_DEPTH=4 and no popin -> tx_full=1 after the 4th; 5th dropped; four popin cycles return packets 1..4 in order.
- Router presents a packet with row=ID_ROW,col=ID_COL -> pop high exactly one cycle; rx_valid=1; rx_data equals the packet; rx_cnt=1.
- Router presents a packet addressed to row=3,col=3 (ID 0,0) -> pop pulses; err_misroute pulses in the GAP cycle; drop_cnt=1; rx_valid stays 0. Repeat with low bits = BDCST -> packet accepted.
- Hold pndng=1 continuously, host never reads -> exactly 4 pops spaced 3 cycles apart, then pop stays 0; one rx_pop -> exactly one further pop.
- Assert reset during POP with 2 packets in each buffer -> all outputs return to 0 asynchronously; FSM in IDLE after release.

Source files
------------

// File: rtl/mesh_ni_pkg.sv
// -----------------------------------------------------------------------------
// mesh_ni_pkg
// Shared definitions for the mesh terminal network interface.
//   - Packet field positions as functions of the packet width, plus the
//     values those functions give for the default 40-bit packet.
//   - rx_state_t : receive-side drain FSM states.
//   - make_pkt   : assembles a packet with a cleared next-jump field.
// Packet layout (MSB first): nxt_jmp[8] | row[4] | col[4] | mode[1] | payload.
// -----------------------------------------------------------------------------
package mesh_ni_pkg;

  localparam int PKT_MAX_W   = 64;
  localparam int PCKG_SZ_DEF = 40;

  function automatic int f_nxt_jmp_msb(input int pckg_sz);
    return pckg_sz - 1;
  endfunction

  function automatic int f_row_msb(input int pckg_sz);
    return pckg_sz - 9;
  endfunction

  function automatic int f_col_msb(input int pckg_sz);
    return pckg_sz - 13;
  endfunction

  function automatic int f_mode_bit(input int pckg_sz);
    return pckg_sz - 17;
  endfunction

  function automatic int f_payload_w(input int pckg_sz);
    return pckg_sz - 17;
  endfunction

  localparam int NXT_JMP_MSB = f_nxt_jmp_msb(PCKG_SZ_DEF);
  localparam int ROW_MSB     = f_row_msb(PCKG_SZ_DEF);
  localparam int COL_MSB     = f_col_msb(PCKG_SZ_DEF);
  localparam int MODE_BIT    = f_mode_bit(PCKG_SZ_DEF);
  localparam int PAYLOAD_W   = f_payload_w(PCKG_SZ_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } rx_state_t;

  // Builds a packet right-aligned in PKT_MAX_W bits; the caller truncates to
  // its own packet width. Payload bits above the payload field are discarded.
  function automatic logic [PKT_MAX_W-1:0] make_pkt(
    input logic [3:0]           row,
    input logic [3:0]           col,
    input logic                 mode,
    input logic [PKT_MAX_W-1:0] payload,
    input int                   pckg_sz
  );
    logic [PKT_MAX_W-1:0] pkt;
    logic [PKT_MAX_W-1:0] mask;
    mask = (PKT_MAX_W'(1) << f_payload_w(pckg_sz)) - PKT_MAX_W'(1);
    pkt  = payload & mask;
    pkt  = pkt | (PKT_MAX_W'(mode) << f_mode_bit(pckg_sz));
    pkt  = pkt | (PKT_MAX_W'(col)  << (f_col_msb(pckg_sz) - 3));
    pkt  = pkt | (PKT_MAX_W'(row)  << (f_row_msb(pckg_sz) - 3));
    return pkt;
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// -----------------------------------------------------------------------------
// ni_fifo
// Synchronous FIFO with a combinational head output.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push     : write i_wdata when not full (ignored when full)
//   i_pop      : drop the head when not empty (ignored when empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_head     : oldest entry, forced to 0 while empty
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module ni_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push_ok;
  logic         w_pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop  && !o_empty;

  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values of the others, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; stale contents are never observed
  // because the head output is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/mesh_term_ni.sv
// -----------------------------------------------------------------------------
// mesh_term_ni
// Terminal network interface for one edge port of the router mesh.
//   TX: host packets (tx_push/tx_row/tx_col/tx_mode/tx_payload, tx_full) are
//       buffered and offered to the router on pndng_i_in/data_out_i_in; the
//       router's popin retires the head.
//   RX: router egress (pndng/data_out) is drained with single-cycle pop
//       pulses (IDLE -> POP -> GAP), address-checked and either queued for
//       the host (rx_valid/rx_data/rx_pop) or dropped with err_misroute.
//   Stats: tx_cnt, rx_cnt, drop_cnt saturating counters.
// Build option: define NI_STATS_EN to build the statistics counters; without
// it the three counter ports are tied to 0.
// reset is asynchronous, active low.
// -----------------------------------------------------------------------------
module mesh_term_ni
  import mesh_ni_pkg::*;
#(
  parameter int                 PCKG_SZ    = 40,
  parameter int                 FIFO_DEPTH = 4,
  parameter int                 ID_ROW     = 0,
  parameter int                 ID_COL     = 0,
  parameter logic [PCKG_SZ-18:0] BDCST     = {1'b0, {(PCKG_SZ-18){1'b1}}},
  parameter int                 CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_push,
  input  logic [3:0]         tx_row,
  input  logic [3:0]         tx_col,
  input  logic               tx_mode,
  input  logic [PCKG_SZ-18:0] tx_payload,
  output logic               tx_full,
  output logic               pndng_i_in,
  output logic [PCKG_SZ-1:0] data_out_i_in,
  input  logic               popin,
  input  logic               pndng,
  input  logic [PCKG_SZ-1:0] data_out,
  output logic               pop,
  input  logic               rx_pop,
  output logic               rx_valid,
  output logic [PCKG_SZ-1:0] rx_data,
  output logic               err_misroute,
  output logic [CNT_W-1:0]   tx_cnt,
  output logic [CNT_W-1:0]   rx_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int         P_ROW_MSB   = f_row_msb(PCKG_SZ);
  localparam int         P_COL_MSB   = f_col_msb(PCKG_SZ);
  localparam int         P_PAYLOAD_W = f_payload_w(PCKG_SZ);
  localparam logic [3:0] P_MY_ROW    = 4'(ID_ROW);
  localparam logic [3:0] P_MY_COL    = 4'(ID_COL);

  logic [PCKG_SZ-1:0] w_tx_wdata;
  logic               w_tx_empty;
  logic               w_rx_full;
  logic               w_rx_empty;
  logic               w_accept;
  logic               w_rx_push;
  logic               w_drop;
  rx_state_t          r_state;
  logic               r_err;

  // ---------------------------------------------------------------- TX path
  assign w_tx_wdata = PCKG_SZ'(make_pkt(tx_row, tx_col, tx_mode,
                                        PKT_MAX_W'(tx_payload), PCKG_SZ));

  ni_fifo #(.W(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (tx_push),
    .i_wdata (w_tx_wdata),
    .i_pop   (popin),
    .o_full  (tx_full),
    .o_empty (w_tx_empty),
    .o_head  (data_out_i_in)
  );

  assign pndng_i_in = !w_tx_empty;

  // ---------------------------------------------------------------- RX path
  // data_out is only meaningful in POP; the router updates it during GAP.
  assign w_accept  = ((data_out[P_ROW_MSB -: 4] == P_MY_ROW) &&
                      (data_out[P_COL_MSB -: 4] == P_MY_COL)) ||
                     (data_out[P_PAYLOAD_W-1:0] == BDCST);
  assign w_rx_push = (r_state == POP) && w_accept;
  assign w_drop    = (r_state == POP) && !w_accept;
  assign pop       = (r_state == POP);

  // Full is the registered pre-edge value, so an rx_pop in the same cycle
  // cannot open the way for a pop until the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_drop;
      case (r_state)
        IDLE:    if (pndng && !w_rx_full) r_state <= POP;
        POP:     r_state <= GAP;
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign err_misroute = r_err;

  ni_fifo #(.W(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_rx_push),
    .i_wdata (data_out),
    .i_pop   (rx_pop),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_head  (rx_data)
  );

  assign rx_valid = !w_rx_empty;

  // ------------------------------------------------------------- statistics
`ifdef NI_STATS_EN
  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_tx_pop_ok;

  assign w_tx_pop_ok = popin && !w_tx_empty;

  // Counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_tx_pop_ok && (r_tx_cnt   != '1)) r_tx_cnt   <= r_tx_cnt   + 1'b1;
      if (w_rx_push   && (r_rx_cnt   != '1)) r_rx_cnt   <= r_rx_cnt   + 1'b1;
      if (w_drop      && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign tx_cnt   = r_tx_cnt;
  assign rx_cnt   = r_rx_cnt;
  assign drop_cnt = r_drop_cnt;
`else
  assign tx_cnt   = '0;
  assign rx_cnt   = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mesh_term_ni.sv
// -----------------------------------------------------------------------------
// tb_mesh_term_ni
// Self-checking bench for mesh_term_ni (default parameters, ID 0,0).
// A queue-based model of both buffers, the pop spacing rule and the counters
// is compared against the DUT on every falling edge; directed sequences add
// hand-computed literal expectations. The router side is a bench queue that
// retires its head after each cycle in which the DUT asserted pop.
// -----------------------------------------------------------------------------
module tb_mesh_term_ni;

  localparam int W = 40;
  localparam int D = 4;
`ifdef NI_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [W-1:0] pkt_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_push = 1'b0;
  logic [3:0]    tx_row = '0;
  logic [3:0]    tx_col = '0;
  logic          tx_mode = 1'b0;
  logic [W-18:0] tx_payload = '0;
  logic          tx_full;
  logic          pndng_i_in;
  pkt_t          data_out_i_in;
  logic          popin = 1'b0;
  logic          pndng = 1'b0;
  pkt_t          data_out = '0;
  logic          pop;
  logic          rx_pop = 1'b0;
  logic          rx_valid;
  pkt_t          rx_data;
  logic          err_misroute;
  logic [15:0]   tx_cnt, rx_cnt, drop_cnt;

  mesh_term_ni dut (
    .clk(clk), .reset(reset),
    .tx_push(tx_push), .tx_row(tx_row), .tx_col(tx_col), .tx_mode(tx_mode),
    .tx_payload(tx_payload), .tx_full(tx_full),
    .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
    .pndng(pndng), .data_out(data_out), .pop(pop),
    .rx_pop(rx_pop), .rx_valid(rx_valid), .rx_data(rx_data),
    .err_misroute(err_misroute),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  pkt_t tx_q[$];
  pkt_t rx_q[$];
  pkt_t rt_q[$];
  int   m_tx_cnt, m_rx_cnt, m_drop_cnt;
  bit   e_pop, e_err;
  int   since_pop;   // cycles since the last pop cycle (0 = pop this cycle)
  int   pre_tx, pre_rx;
  bit   n_pop, n_err, acc;

  function automatic pkt_t pk(input int row, input int col, input int mode,
                              input int payload);
    pkt_t p;
    p        = '0;
    p[31:28] = row[3:0];
    p[27:24] = col[3:0];
    p[23]    = mode[0];
    p[22:0]  = payload[22:0];
    return p;
  endfunction

  function automatic bit addr_ok(input pkt_t p);
    return (p[31:28] == 4'd0 && p[27:24] == 4'd0) || (p[22:0] == 23'h3FFFFF);
  endfunction

  function automatic int sat(input int c);
    return (c >= 65535) ? c : c + 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q.delete(); rx_q.delete();
      m_tx_cnt = 0; m_rx_cnt = 0; m_drop_cnt = 0;
      e_pop = 1'b0; e_err = 1'b0; since_pop = 2;
    end else begin
      pre_tx = tx_q.size(); pre_rx = rx_q.size();
      n_pop = 1'b0; n_err = 1'b0; acc = 1'b0;
      if (e_pop) begin
        if (addr_ok(data_out)) begin acc = 1'b1; m_rx_cnt = sat(m_rx_cnt); end
        else begin n_err = 1'b1; m_drop_cnt = sat(m_drop_cnt); end
      end else if (since_pop >= 2 && pndng && pre_rx < D) begin
        n_pop = 1'b1;
      end
      if (rx_pop && pre_rx > 0) void'(rx_q.pop_front());
      if (acc) rx_q.push_back(data_out);
      if (popin && pre_tx > 0) begin
        void'(tx_q.pop_front());
        m_tx_cnt = sat(m_tx_cnt);
      end
      if (tx_push && pre_tx < D) tx_q.push_back(pk(tx_row, tx_col, tx_mode, tx_payload));
      since_pop = n_pop ? 0 : ((since_pop < 100) ? since_pop + 1 : since_pop);
      e_pop = n_pop;
      e_err = n_err;
    end
  end

  // -------------------------------------------------------------- compare
  always @(negedge clk) begin
    check("pndng_i_in",    pndng_i_in,    tx_q.size() > 0);
    check("data_out_i_in", data_out_i_in, (tx_q.size() > 0) ? tx_q[0] : '0);
    check("tx_full",       tx_full,       tx_q.size() == D);
    check("pop",           pop,           e_pop);
    check("err_misroute",  err_misroute,  e_err);
    check("rx_valid",      rx_valid,      rx_q.size() > 0);
    check("rx_data",       rx_data,       (rx_q.size() > 0) ? rx_q[0] : '0);
    check("tx_cnt",        tx_cnt,        STATS ? m_tx_cnt : 0);
    check("rx_cnt",        rx_cnt,        STATS ? m_rx_cnt : 0);
    check("drop_cnt",      drop_cnt,      STATS ? m_drop_cnt : 0);
  end

  // --------------------------------------------------------------- router
  task automatic drive_rt();
    pndng    = (rt_q.size() > 0);
    data_out = (rt_q.size() > 0) ? rt_q[0] : '0;
  endtask

  // One clock cycle; called and returning at falling edge + 1.
  task automatic tick();
    bit p;
    p = pop;
    @(posedge clk);
    #1;
    if (p && rt_q.size() > 0) void'(rt_q.pop_front());
    drive_rt();
    @(negedge clk);
    #1;
  endtask

  int npop, nerr, pc, ec, j;
  int pop_t[$];
  bit found;

  task automatic window(input int n);
    npop = 0; nerr = 0; pc = -1; ec = -1;
    for (int i = 0; i < n; i++) begin
      if (pop)          begin npop++; pc = i; end
      if (err_misroute) begin nerr++; ec = i; end
      tick();
    end
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    drive_rt();
    repeat (3) @(negedge clk);
    #1;
    check("rst_pndng_i_in", pndng_i_in, 0);
    check("rst_data_out_i_in", data_out_i_in, 0);
    check("rst_pop", pop, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_full", tx_full, 0);
    reset = 1'b1;
    tick();

    // single TX packet
    tx_row = 4'd2; tx_col = 4'd1; tx_mode = 1'b0; tx_payload = 23'h5A;
    tx_push = 1'b1; tick(); tx_push = 1'b0;
    check("t1_pndng", pndng_i_in, 1);
    check("t1_data", data_out_i_in, 40'h002100005A);
    popin = 1'b1; tick(); popin = 1'b0;
    check("t1_pndng_after_popin", pndng_i_in, 0);
    check("t1_tx_cnt", tx_cnt, STATS ? 1 : 0);

    // fill TX, overflow push ignored, drain in order
    for (int k = 1; k <= 5; k++) begin
      tx_row = 4'd1; tx_col = 4'd1; tx_payload = 23'(k);
      tx_push = 1'b1; tick();
      if (k == 4) check("t2_full_after_4", tx_full, 1);
    end
    tx_push = 1'b0;
    check("t2_full_after_5", tx_full, 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t2_head_%0d", k), data_out_i_in, 40'h0011000000 + 40'(k));
      popin = 1'b1; tick();
    end
    popin = 1'b0;
    check("t2_pndng_empty", pndng_i_in, 0);
    check("t2_tx_full_clear", tx_full, 0);
    check("t2_tx_cnt", tx_cnt, STATS ? 5 : 0);

    // RX accepted packet
    rt_q.push_back(40'h0000000123); drive_rt();
    window(8);
    check("t3_pop_count", npop, 1);
    check("t3_rx_valid", rx_valid, 1);
    check("t3_rx_data", rx_data, 40'h0000000123);
    check("t3_rx_cnt", rx_cnt, STATS ? 1 : 0);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    check("t3_rx_valid_after_read", rx_valid, 0);

    // misrouted packet dropped
    rt_q.push_back(40'h0033000077); drive_rt();
    window(8);
    check("t4_pop_count", npop, 1);
    check("t4_err_count", nerr, 1);
    check("t4_err_in_gap", ec, pc + 1);
    check("t4_rx_valid", rx_valid, 0);
    check("t4_drop_cnt", drop_cnt, STATS ? 1 : 0);

    // broadcast payload accepted regardless of address
    rt_q.push_back(40'h00333FFFFF); drive_rt();
    window(8);
    check("t4_bdcst_err", nerr, 0);
    check("t4_bdcst_rx_data", rx_data, 40'h00333FFFFF);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;

    // all-ones payload is not the broadcast value
    rt_q.push_back(40'h00337FFFFF); drive_rt();
    window(8);
    check("t4_near_bdcst_err", nerr, 1);
    check("t4_near_bdcst_rx_valid", rx_valid, 0);
    check("t4_drop_cnt_2", drop_cnt, STATS ? 2 : 0);

    // backpressure: host never reads
    for (int i = 0; i < 6; i++) rt_q.push_back(40'h0000000010 + 40'(i));
    drive_rt();
    pop_t.delete();
    for (int i = 0; i < 24; i++) begin
      if (pop) pop_t.push_back(i);
      tick();
    end
    check("t5_pop_count", pop_t.size(), 4);
    if (pop_t.size() == 4)
      for (int i = 1; i < 4; i++)
        check($sformatf("t5_spacing_%0d", i), pop_t[i] - pop_t[i-1], 3);
    check("t5_rx_head", rx_data, 40'h0000000010);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    window(10);
    check("t5_extra_pop", npop, 1);
    j = 1;
    for (int i = 0; i < 40 && j < 6; i++) begin
      if (rx_valid) begin
        check($sformatf("t5_drain_%0d", j), rx_data, 40'h0000000010 + 40'(j));
        j++;
        rx_pop = 1'b1;
      end else begin
        rx_pop = 1'b0;
      end
      tick();
    end
    rx_pop = 1'b0;
    check("t5_drain_done", j, 6);
    tick();

    // asynchronous reset while a POP is in flight
    tx_row = 4'd5; tx_col = 4'd6; tx_payload = 23'h1;
    tx_push = 1'b1; tick(); tick(); tx_push = 1'b0;
    for (int i = 0; i < 3; i++) rt_q.push_back(40'h0000000020 + 40'(i));
    drive_rt();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pop && rx_q.size() == 2) begin found = 1'b1; break; end
      tick();
    end
    check("t6_reached_pop", found, 1);
    reset = 1'b0;
    #1;
    check("t6_pop", pop, 0);
    check("t6_pndng_i_in", pndng_i_in, 0);
    check("t6_data_out_i_in", data_out_i_in, 0);
    check("t6_rx_valid", rx_valid, 0);
    check("t6_rx_data", rx_data, 0);
    check("t6_tx_full", tx_full, 0);
    check("t6_err", err_misroute, 0);
    check("t6_cnts", {tx_cnt, rx_cnt, drop_cnt}, 0);
    rt_q.delete(); drive_rt();
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    check("t6_idle_pop", pop, 0);
    rt_q.push_back(40'h0000000099); drive_rt();
    window(6);
    check("t6_post_pop_count", npop, 1);
    check("t6_post_rx_data", rx_data, 40'h0000000099);
    check("t6_post_rx_cnt", rx_cnt, STATS ? 1 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
